dwxz_grad_accum: RTL and testbench

//  Downstream of the dh/dWxz stage. Sums the four per-time-step gradient lanes over one

---
 rtl/dwxz_grad_accum_if.sv | 31 +++
 rtl/dwxz_grad_accum.sv | 132 +++++++++++++
 tb/tb_dwxz_grad_accum.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dwxz_grad_accum_if.sv
// Handshake bundle between the dh/dWxz stage and the Wxz gradient accumulator.
// master = upstream sample/weight source, slave = dwxz_grad_accum.
interface dwxz_grad_accum_if #(
    parameter int unsigned DATABIT = 16,
    parameter int unsigned CNTBIT  = 3
);
    localparam int unsigned WNUM = 4 * DATABIT;

    logic                      start;
    logic                      in_valid;
    logic signed [DATABIT-1:0] grad_0;
    logic signed [DATABIT-1:0] grad_1;
    logic signed [DATABIT-1:0] grad_2;
    logic signed [DATABIT-1:0] grad_3;
    logic [WNUM-1:0]           w_in;
    logic [WNUM-1:0]           w_out;
    logic                      w_valid;
    logic                      busy;
    logic [CNTBIT-1:0]         step_cnt;
    logic                      ovf;

    modport master (
        output start, in_valid, grad_0, grad_1, grad_2, grad_3, w_in,
        input  w_out, w_valid, busy, step_cnt, ovf
    );

    modport slave (
        input  start, in_valid, grad_0, grad_1, grad_2, grad_3, w_in,
        output w_out, w_valid, busy, step_cnt, ovf
    );
endinterface

// File: rtl/dwxz_grad_accum.sv
// Accumulates four gradient lanes over a BPTT sequence, then applies a
// shift-scaled SGD step to the Wxz weights with saturation.
module dwxz_grad_accum #(
    parameter int unsigned DATABIT  = 16,
    parameter int unsigned ACCBIT   = 24,
    parameter int unsigned T_STEPS  = 4,
    parameter int unsigned CNTBIT   = 3,
    parameter int unsigned LR_SHIFT = 2,
    parameter int unsigned WNUM     = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    dwxz_grad_accum_if.slave bus
);
    localparam int unsigned SUMBIT = ACCBIT + 1;
    localparam int unsigned HIBIT  = SUMBIT - DATABIT + 1;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] ACCUM  = 2'b01;
    localparam logic [1:0] UPDATE = 2'b10;

    localparam logic [ACCBIT-1:0]  ACC_MIN  = {1'b1, {(ACCBIT-1){1'b0}}};
    localparam logic [ACCBIT-1:0]  ACC_MAX  = {1'b0, {(ACCBIT-1){1'b1}}};
    localparam logic [DATABIT-1:0] DATA_MIN = {1'b1, {(DATABIT-1){1'b0}}};
    localparam logic [DATABIT-1:0] DATA_MAX = {1'b0, {(DATABIT-1){1'b1}}};

    logic [1:0]                state, state_nxt;
    logic signed [ACCBIT-1:0]  acc      [4];
    logic signed [ACCBIT-1:0]  acc_nxt  [4];
    logic signed [SUMBIT-1:0]  acc_sum  [4];
    logic signed [ACCBIT-1:0]  acc_shr  [4];
    logic signed [SUMBIT-1:0]  w_diff   [4];
    logic signed [DATABIT-1:0] grad     [4];
    logic [HIBIT-1:0]          w_hi     [4];
    logic [WNUM-1:0]           w_nxt;
    logic                      acc_clip;
    logic                      w_clip;
    logic                      last_sample;

    logic [WNUM-1:0]           w_out;
    logic                      w_valid;
    logic                      busy;
    logic [CNTBIT-1:0]         step_cnt;
    logic                      ovf;

    assign grad[0] = bus.grad_0;
    assign grad[1] = bus.grad_1;
    assign grad[2] = bus.grad_2;
    assign grad[3] = bus.grad_3;

    assign last_sample = bus.in_valid && (step_cnt == CNTBIT'(T_STEPS - 1));

    // State register; busy is registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt != IDLE);
        end
    end

    // Next-state logic; start always wins and (re)enters ACCUM
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = ACCUM;
            ACCUM:   if (bus.start) state_nxt = ACCUM;
                     else if (last_sample) state_nxt = UPDATE;
            UPDATE:  state_nxt = bus.start ? ACCUM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Saturating lane accumulate and saturating weight step
    always_comb begin
        acc_clip = 1'b0;
        w_clip   = 1'b0;
        w_nxt    = '0;
        for (int k = 0; k < 4; k++) begin
            acc_sum[k] = SUMBIT'(acc[k]) + SUMBIT'(grad[k]);
            if (acc_sum[k][ACCBIT] != acc_sum[k][ACCBIT-1]) begin
                acc_nxt[k] = acc_sum[k][ACCBIT] ? ACC_MIN : ACC_MAX;
                acc_clip   = 1'b1;
            end else begin
                acc_nxt[k] = acc_sum[k][ACCBIT-1:0];
            end
            acc_shr[k] = acc[k] >>> LR_SHIFT;
            w_diff[k]  = SUMBIT'(signed'(bus.w_in[k*DATABIT +: DATABIT])) - SUMBIT'(acc_shr[k]);
            w_hi[k]    = w_diff[k][ACCBIT:DATABIT-1];
            if ((&w_hi[k]) || !(|w_hi[k])) begin
                w_nxt[k*DATABIT +: DATABIT] = w_diff[k][DATABIT-1:0];
            end else begin
                w_nxt[k*DATABIT +: DATABIT] = w_diff[k][ACCBIT] ? DATA_MIN : DATA_MAX;
                w_clip = 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '{default: '0};
            step_cnt <= '0;
            w_out    <= '0;
            w_valid  <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            w_valid <= 1'b0;
            if (bus.start) begin
                acc      <= '{default: '0};
                step_cnt <= '0;
                ovf      <= 1'b0;
            end else if (state == ACCUM && bus.in_valid) begin
                acc      <= acc_nxt;
                ovf      <= ovf | acc_clip;
                step_cnt <= last_sample ? '0 : step_cnt + 1'b1;
            end else if (state == UPDATE) begin
                w_out   <= w_nxt;
                w_valid <= 1'b1;
                ovf     <= ovf | w_clip;
            end
        end
    end

    assign bus.w_out    = w_out;
    assign bus.w_valid  = w_valid;
    assign bus.busy     = busy;
    assign bus.step_cnt = step_cnt;
    assign bus.ovf      = ovf;
endmodule

// File: tb/tb_dwxz_grad_accum.sv
// Bench for dwxz_grad_accum: directed scenarios plus randomized sequences
// checked against an integer-arithmetic model of the SGD accumulator.
module tb_dwxz_grad_accum;
    localparam int unsigned DATABIT  = 16;
    localparam int unsigned ACCBIT   = 24;
    localparam int unsigned T_STEPS  = 4;
    localparam int unsigned CNTBIT   = 3;
    localparam int unsigned LR_SHIFT = 2;
    localparam int unsigned WNUM     = 64;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dwxz_grad_accum_if #(.DATABIT(DATABIT), .CNTBIT(CNTBIT)) bus ();

    dwxz_grad_accum #(
        .DATABIT(DATABIT), .ACCBIT(ACCBIT), .T_STEPS(T_STEPS),
        .CNTBIT(CNTBIT), .LR_SHIFT(LR_SHIFT), .WNUM(WNUM)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int     n_pass  = 0;
    int     n_total = 0;
    longint m_acc [4];
    bit     m_ovf;

    function automatic longint clamp(input longint v, input int w, inout bit flag);
        longint lo = -(64'sd1 <<< (w - 1));
        longint hi = (64'sd1 <<< (w - 1)) - 1;
        if (v > hi) begin flag = 1'b1; return hi; end
        if (v < lo) begin flag = 1'b1; return lo; end
        return v;
    endfunction

    // Expected weights after the SGD step; folds any weight clamp into m_ovf
    function automatic logic [WNUM-1:0] model_w(input logic [WNUM-1:0] w_in);
        logic [WNUM-1:0] r = '0;
        logic signed [DATABIT-1:0] lane;
        bit f;
        longint e;
        for (int k = 0; k < 4; k++) begin
            lane = w_in[k*DATABIT +: DATABIT];
            f = m_ovf;
            e = clamp(longint'(lane) - (m_acc[k] >>> LR_SHIFT), DATABIT, f);
            m_ovf = f;
            r[k*DATABIT +: DATABIT] = e[DATABIT-1:0];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < 4; k++) m_acc[k] = 0;
        m_ovf = 1'b0;
    endtask

    task automatic set_grads(input logic signed [15:0] g0, g1, g2, g3);
        bus.grad_0 = g0; bus.grad_1 = g1; bus.grad_2 = g2; bus.grad_3 = g3;
    endtask

    task automatic drive_sample(input logic signed [15:0] g0, g1, g2, g3);
        logic signed [15:0] g [4];
        bit f;
        g[0] = g0; g[1] = g1; g[2] = g2; g[3] = g3;
        set_grads(g0, g1, g2, g3);
        bus.start = 1'b0;
        bus.in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            f = m_ovf;
            m_acc[k] = clamp(m_acc[k] + longint'(g[k]), ACCBIT, f);
            m_ovf = f;
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        bus.in_valid = 1'($urandom_range(0, 1));
        set_grads(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
        tick();
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.start = 1'($urandom); bus.in_valid = 1'($urandom);
            set_grads(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
            bus.w_in = {$urandom, $urandom};
            tick();
        end
        n_total++; if (bus.w_out !== '0) $display("FAIL reset_w_out: got %h want 0", bus.w_out); else n_pass++;
        n_total++; if (bus.w_valid !== 1'b0) $display("FAIL reset_w_valid: got %b want 0", bus.w_valid); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.ovf !== 1'b0) $display("FAIL reset_ovf: got %b want 0", bus.ovf); else n_pass++;
        n_total++; if (bus.step_cnt !== '0) $display("FAIL reset_step_cnt: got %0d want 0", bus.step_cnt); else n_pass++;
        bus.start = 1'b0; bus.in_valid = 1'b0;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        bus.w_in = {16'h0000, 16'h0000, 16'h0123, 16'h1000};
        do_start();
        n_total++; if (bus.busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", bus.busy); else n_pass++;
        for (int i = 0; i < 4; i++) drive_sample(16'sh0100, 16'sh0, 16'sh0, 16'sh0);
        n_total++; if (bus.w_valid !== 1'b0) $display("FAIL basic_early_valid: got %b want 0", bus.w_valid); else n_pass++;
        tick();
        n_total++; if (bus.w_valid !== 1'b1) $display("FAIL basic_w_valid: got %b want 1", bus.w_valid); else n_pass++;
        n_total++;
        if (bus.w_out !== 64'h0000_0000_0123_0F00) $display("FAIL basic_w_out: got %h want 0000000001230f00", bus.w_out);
        else n_pass++;
        n_total++; if (bus.ovf !== 1'b0) $display("FAIL basic_ovf: got %b want 0", bus.ovf); else n_pass++;
        tick();
        n_total++; if (bus.w_valid !== 1'b0) $display("FAIL basic_pulse_len: got %b want 0", bus.w_valid); else n_pass++;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL basic_idle: got %b want 0", bus.busy); else n_pass++;
        n_total++;
        if (bus.w_out !== 64'h0000_0000_0123_0F00) $display("FAIL basic_hold: got %h want 0000000001230f00", bus.w_out);
        else n_pass++;
    endtask

    task automatic test_neg_gaps();
        bus.w_in = {16'h0000, 16'h0005, 16'h0000, 16'h0000};
        do_start();
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) tick();
            n_total++;
            if (bus.step_cnt !== CNTBIT'(i)) $display("FAIL gaps_step_cnt: got %0d want %0d", bus.step_cnt, i);
            else n_pass++;
            drive_sample(16'sh0, 16'sh0, -16'sd8, 16'sh0);
        end
        tick();
        n_total++; if (bus.w_valid !== 1'b1) $display("FAIL gaps_w_valid: got %b want 1", bus.w_valid); else n_pass++;
        n_total++;
        if (bus.w_out !== 64'h0000_000D_0000_0000) $display("FAIL gaps_w_out: got %h want 0000000d00000000", bus.w_out);
        else n_pass++;
        tick();
    endtask

    task automatic test_saturation();
        bus.w_in = {16'h7FF0, 16'h0000, 16'h0000, 16'h0000};
        do_start();
        for (int i = 0; i < 4; i++) drive_sample(16'sh0, 16'sh0, 16'sh0, -16'sh4000);
        tick();
        n_total++;
        if (bus.w_out !== 64'h7FFF_0000_0000_0000) $display("FAIL sat_w_out: got %h want 7fff000000000000", bus.w_out);
        else n_pass++;
        n_total++; if (bus.ovf !== 1'b1) $display("FAIL sat_ovf: got %b want 1", bus.ovf); else n_pass++;
        tick();
        n_total++; if (bus.ovf !== 1'b1) $display("FAIL sat_ovf_sticky: got %b want 1", bus.ovf); else n_pass++;
        do_start();
        n_total++; if (bus.ovf !== 1'b0) $display("FAIL sat_ovf_clear: got %b want 0", bus.ovf); else n_pass++;
    endtask

    task automatic test_restart();
        bus.w_in = {16'h0000, 16'h0000, 16'h0000, 16'h1000};
        do_start();
        for (int i = 0; i < 2; i++) drive_sample(16'sh0100, 16'sh0, 16'sh0, 16'sh0);
        bus.start = 1'b1; bus.in_valid = 1'b1;
        set_grads(16'sh0100, 16'sh0, 16'sh0, 16'sh0);
        tick();
        bus.start = 1'b0; bus.in_valid = 1'b0;
        model_clear();
        n_total++; if (bus.step_cnt !== '0) $display("FAIL restart_step_cnt: got %0d want 0", bus.step_cnt); else n_pass++;
        for (int i = 0; i < 4; i++) drive_sample(16'sh0040, 16'sh0, 16'sh0, 16'sh0);
        tick();
        n_total++;
        if (bus.w_out !== 64'h0000_0000_0000_0FC0) $display("FAIL restart_w_out: got %h want 0000000000000fc0", bus.w_out);
        else n_pass++;
        tick();
    endtask

    task automatic test_start_in_update();
        logic [WNUM-1:0] prev;
        prev = bus.w_out;
        bus.w_in = {$urandom, $urandom};
        do_start();
        for (int i = 0; i < 4; i++) drive_sample(16'sh1234, 16'sh0, 16'sh0, 16'sh0);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        model_clear();
        n_total++; if (bus.w_valid !== 1'b0) $display("FAIL upd_start_valid: got %b want 0", bus.w_valid); else n_pass++;
        n_total++; if (bus.w_out !== prev) $display("FAIL upd_start_w_out: got %h want %h", bus.w_out, prev); else n_pass++;
        n_total++; if (bus.busy !== 1'b1) $display("FAIL upd_start_busy: got %b want 1", bus.busy); else n_pass++;
        for (int i = 0; i < 4; i++) drive_sample(16'sh0, 16'sh0, 16'sh0, 16'sh0);
        tick();
        n_total++;
        if (bus.w_out !== bus.w_in) $display("FAIL upd_start_acc_clr: got %h want %h", bus.w_out, bus.w_in);
        else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid();
        int seen;
        bus.w_in = {16'h0000, 16'h0000, 16'h0000, 16'h1000};
        do_start();
        for (int i = 0; i < 3; i++) drive_sample(16'sh0100, 16'sh0, 16'sh0, 16'sh0);
        #2 rst_n = 1'b0;
        #1;
        n_total++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", bus.busy); else n_pass++;
        n_total++; if (bus.step_cnt !== '0) $display("FAIL midrst_step_cnt: got %0d want 0", bus.step_cnt); else n_pass++;
        n_total++; if (bus.w_out !== '0) $display("FAIL midrst_w_out: got %h want 0", bus.w_out); else n_pass++;
        tick();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            bus.in_valid = 1'b1;
            set_grads(16'sh0100, 16'sh0, 16'sh0, 16'sh0);
            tick();
            if (bus.w_valid !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        bus.in_valid = 1'b0;
        tick();
        n_total++; if (seen != 0) $display("FAIL midrst_no_update: got %0d active cycles want 0", seen); else n_pass++;
    endtask

    task automatic test_random();
        logic [WNUM-1:0] w, exp_w;
        int acc_n;
        for (int s = 0; s < 25; s++) begin
            w = {$urandom, $urandom};
            bus.w_in = w;
            do_start();
            acc_n = 0;
            while (acc_n < 4) begin
                for (int j = 0; j < int'($urandom_range(0, 2)); j++) tick();
                if ($urandom_range(0, 15) == 0) begin
                    bus.start = 1'b1; bus.in_valid = 1'b1;
                    set_grads(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
                    tick();
                    bus.start = 1'b0; bus.in_valid = 1'b0;
                    model_clear();
                    acc_n = 0;
                end else begin
                    drive_sample(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom));
                    acc_n++;
                end
            end
            exp_w = model_w(w);
            n_total++; if (bus.w_valid !== 1'b0) $display("FAIL rnd%0d_early: got %b want 0", s, bus.w_valid); else n_pass++;
            tick();
            n_total++; if (bus.w_valid !== 1'b1) $display("FAIL rnd%0d_w_valid: got %b want 1", s, bus.w_valid); else n_pass++;
            n_total++; if (bus.w_out !== exp_w) $display("FAIL rnd%0d_w_out: got %h want %h", s, bus.w_out, exp_w); else n_pass++;
            n_total++; if (bus.ovf !== m_ovf) $display("FAIL rnd%0d_ovf: got %b want %b", s, bus.ovf, m_ovf); else n_pass++;
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.w_in = '0;
        set_grads(16'sh0, 16'sh0, 16'sh0, 16'sh0);
        model_clear();
        test_reset();
        test_basic();
        test_neg_gaps();
        test_saturation();
        test_restart();
        test_start_in_update();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
